// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the shared memory.
// slave = arbiter side, master = requester/memory side.
interface mem_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  if_req;
  logic [DATA_WIDTH-1:0] if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_WIDTH-1:0] if_rdata;

  logic                  dm_req;
  logic                  dm_we;
  logic [DATA_WIDTH-1:0] dm_addr;
  logic [DATA_WIDTH-1:0] dm_wdata;
  logic                  dm_gnt;
  logic                  dm_rvalid;
  logic [DATA_WIDTH-1:0] dm_rdata;

  logic                  mem_en;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  busy;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: data accesses win over fetches, but a waiting fetch
// is forced through after MAX_DM_STREAK consecutive data grants.
module mem_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  mem_arbiter_if.slave bus
);
  localparam int SW = $clog2(MAX_DM_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] IF_RD = 2'd1;
  localparam logic [1:0] DM_RD = 2'd2;

  logic [1:0]            r_state;
  logic [SW-1:0]         r_streak;

  logic                  w_if_force;
  logic                  w_if_gnt;
  logic                  w_dm_gnt;
  logic [DATA_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_wdata;
  logic                  w_if_rvalid;
  logic                  w_dm_rvalid;

  // Grants are gated by rst so every output is low while reset is held.
  assign w_if_force = bus.if_req && (r_streak == STREAK_MAX);
  assign w_dm_gnt   = rst && bus.dm_req && !w_if_force;
  assign w_if_gnt   = rst && bus.if_req && !w_dm_gnt;

  always_comb begin
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    if (w_if_gnt) begin
      w_mem_addr = bus.if_addr;
    end else if (w_dm_gnt) begin
      w_mem_addr = bus.dm_addr;
      if (bus.dm_we) w_mem_wdata = bus.dm_wdata;
    end
  end

  assign bus.if_gnt    = w_if_gnt;
  assign bus.dm_gnt    = w_dm_gnt;
  assign bus.mem_en    = w_if_gnt || w_dm_gnt;
  assign bus.mem_we    = w_dm_gnt && bus.dm_we;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;

  assign w_if_rvalid   = (r_state == IF_RD);
  assign w_dm_rvalid   = (r_state == DM_RD);
  assign bus.if_rvalid = w_if_rvalid;
  assign bus.dm_rvalid = w_dm_rvalid;
  assign bus.if_rdata  = w_if_rvalid ? bus.mem_rdata : '0;
  assign bus.dm_rdata  = w_dm_rvalid ? bus.mem_rdata : '0;
  assign bus.busy      = (r_state != IDLE);

  // State only records whose read response lands next cycle; reset drops it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else if (w_if_gnt) begin
      r_state <= IF_RD;
    end else if (w_dm_gnt && !bus.dm_we) begin
      r_state <= DM_RD;
    end else begin
      r_state <= IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_streak <= '0;
    end else if (!bus.if_req || w_if_gnt) begin
      r_streak <= '0;
    end else if (w_dm_gnt && (r_streak != STREAK_MAX)) begin
      r_streak <= r_streak + SW'(1);
    end
  end
endmodule
